// File: rtl/arm_mem_stage_pkg.sv
// Shared pipeline encodings for the ARM memory stage: FSM states, access size
// and write-back source select.
package arm_mem_stage_pkg;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  typedef enum logic {
    SIZE_WORD = 1'b0,
    SIZE_BYTE = 1'b1
  } mem_size_e;

  typedef enum logic {
    WB_SEL_ALU  = 1'b0,
    WB_SEL_LOAD = 1'b1
  } wb_sel_e;

  localparam int unsigned WAIT_CNT_MIN_W = 8;

endpackage

// File: rtl/arm_mem_align.sv
// Byte-lane steering for the data-memory port: store enables/data replication
// and little-endian load extraction with zero extension.
module arm_mem_align
  import arm_mem_stage_pkg::*;
(
  input  logic [1:0]  byte_off,
  input  logic        size,
  input  logic [3:0]  word_we,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  lane_we,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    lane_we    = word_we;
    lane_wdata = store_data;
    load_data  = rdata;
    if (size == SIZE_BYTE) begin
      lane_we    = 4'b0001 << byte_off;
      lane_wdata = {4{store_data[7:0]}};
      load_data  = 32'(rdata[{byte_off, 3'b000} +: 8]);
    end
  end

endmodule

// File: rtl/arm_mem_stage.sv
// Memory stage: req/ack data-memory handshake, front-end stall, MEM->ID forwarding
// and the MEM/WB register. Optional wait-state timeout under ARM_MEM_TIMEOUT_EN.
module arm_mem_stage
  import arm_mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EXMEM_data_result,
  input  logic [31:0] EXMEM_rd_data,
  input  logic        EXMEM_rd_we,
  input  logic        EXMEM_rd_data_sel,
  input  logic [3:0]  EXMEM_des_reg_num,
  input  logic [3:0]  EXMEM_mem_write_en,
  input  logic        EXMEM_ld_byte_or_word,
  input  logic        EXMEM_is_alu_for_mem_addr,
  input  logic        EXMEM_internal_halted,
  output logic        dmem_req,
  output logic [29:0] dmem_addr,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        MEMID_rd_we,
  output logic [3:0]  MEMID_rd_num,
  output logic [31:0] MEMID_forward_data,
  output logic [31:0] MEMWB_wb_data,
  output logic        MEMWB_rd_we,
  output logic [3:0]  MEMWB_des_reg_num,
  output logic        MEMWB_internal_halted,
  output logic        mem_err
);

  mem_state_e  state, state_nxt;
  logic        mop, st, drop, bubble;
  logic [3:0]  lane_we;
  logic [31:0] lane_wdata, load_data, wb_next;

  assign mop = EXMEM_is_alu_for_mem_addr;
  assign st  = mop & (|EXMEM_mem_write_en);

  arm_mem_align u_align (
    .byte_off   (EXMEM_data_result[1:0]),
    .size       (EXMEM_ld_byte_or_word),
    .word_we    (EXMEM_mem_write_en),
    .store_data (EXMEM_rd_data),
    .rdata      (dmem_rdata),
    .lane_we    (lane_we),
    .lane_wdata (lane_wdata),
    .load_data  (load_data)
  );

`ifdef ARM_MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > WAIT_CNT_MIN_W) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : WAIT_CNT_MIN_W;
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  // Fires in the TIMEOUT_CYCLES-th WAIT cycle; the counter sits at zero on entry.
  assign drop = (state == MEM_WAIT) & ~dmem_ack &
                (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == MEM_IDLE) wait_cnt <= '0;
      else if (!dmem_ack)    wait_cnt <= wait_cnt + 1'b1;
      if (drop) err_q <= 1'b1;
    end
  end

  assign mem_err = err_q;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign drop    = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    dmem_req  = 1'b0;
    unique case (state)
      MEM_IDLE: begin
        dmem_req = mop;
        if (mop && !dmem_ack) state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack || drop) state_nxt = MEM_IDLE;
      end
    endcase
    // Reset must pull the request down at once, even while EX/MEM still holds a memory op.
    if (rst) dmem_req = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= MEM_IDLE;
    else     state <= state_nxt;
  end

  assign dmem_addr  = EXMEM_data_result[31:2];
  assign dmem_we    = (dmem_req & st) ? lane_we : 4'b0000;
  assign dmem_wdata = lane_wdata;

  assign mem_stall = dmem_req & ~dmem_ack & ~drop;
  assign bubble    = mem_stall | drop;
  assign wb_next   = (EXMEM_rd_data_sel == WB_SEL_LOAD) ? load_data : EXMEM_data_result;

  // A dropped (timed-out) instruction must not be forwarded either.
  assign MEMID_rd_we        = EXMEM_rd_we & ~bubble;
  assign MEMID_rd_num       = EXMEM_des_reg_num;
  assign MEMID_forward_data = wb_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MEMWB_wb_data         <= '0;
      MEMWB_rd_we           <= 1'b0;
      MEMWB_des_reg_num     <= '0;
      MEMWB_internal_halted <= 1'b0;
    end else if (bubble) begin
      MEMWB_rd_we           <= 1'b0;
      MEMWB_internal_halted <= 1'b0;
    end else begin
      MEMWB_wb_data         <= wb_next;
      MEMWB_rd_we           <= EXMEM_rd_we;
      MEMWB_des_reg_num     <= EXMEM_des_reg_num;
      MEMWB_internal_halted <= EXMEM_internal_halted;
    end
  end

endmodule

// File: tb/tb_arm_mem_stage.sv
// Self-checking bench for arm_mem_stage: directed vector table, random
// instructions against a transaction-level model, reset and timeout sequences.
module tb_arm_mem_stage;
  import arm_mem_stage_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk, rst;
  logic [31:0] EXMEM_data_result, EXMEM_rd_data;
  logic        EXMEM_rd_we, EXMEM_rd_data_sel;
  logic [3:0]  EXMEM_des_reg_num, EXMEM_mem_write_en;
  logic        EXMEM_ld_byte_or_word, EXMEM_is_alu_for_mem_addr, EXMEM_internal_halted;
  logic        dmem_req;
  logic [29:0] dmem_addr;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall, MEMID_rd_we;
  logic [3:0]  MEMID_rd_num;
  logic [31:0] MEMID_forward_data, MEMWB_wb_data;
  logic        MEMWB_rd_we;
  logic [3:0]  MEMWB_des_reg_num;
  logic        MEMWB_internal_halted, mem_err;

  arm_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .EXMEM_data_result         (EXMEM_data_result),
    .EXMEM_rd_data             (EXMEM_rd_data),
    .EXMEM_rd_we               (EXMEM_rd_we),
    .EXMEM_rd_data_sel         (EXMEM_rd_data_sel),
    .EXMEM_des_reg_num         (EXMEM_des_reg_num),
    .EXMEM_mem_write_en        (EXMEM_mem_write_en),
    .EXMEM_ld_byte_or_word     (EXMEM_ld_byte_or_word),
    .EXMEM_is_alu_for_mem_addr (EXMEM_is_alu_for_mem_addr),
    .EXMEM_internal_halted     (EXMEM_internal_halted),
    .dmem_req                  (dmem_req),
    .dmem_addr                 (dmem_addr),
    .dmem_we                   (dmem_we),
    .dmem_wdata                (dmem_wdata),
    .dmem_ack                  (dmem_ack),
    .dmem_rdata                (dmem_rdata),
    .mem_stall                 (mem_stall),
    .MEMID_rd_we               (MEMID_rd_we),
    .MEMID_rd_num              (MEMID_rd_num),
    .MEMID_forward_data        (MEMID_forward_data),
    .MEMWB_wb_data             (MEMWB_wb_data),
    .MEMWB_rd_we               (MEMWB_rd_we),
    .MEMWB_des_reg_num         (MEMWB_des_reg_num),
    .MEMWB_internal_halted     (MEMWB_internal_halted),
    .mem_err                   (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Last committed write-back data/register, tracked from expectations only.
  logic [31:0] last_wb;
  logic [3:0]  last_des;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rd_data;
    logic        rd_we;
    logic        sel;
    logic [3:0]  des;
    logic [3:0]  we_en;
    logic        byte_sz;
    logic        mop;
    logic        halted;
    int          n_wait;
    logic [31:0] rdata;
    logic [31:0] exp_wb;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  function automatic vec_t mk(logic [31:0] addr, logic [31:0] rd_data, logic rd_we, logic sel,
                              logic [3:0] des, logic [3:0] we_en, logic byte_sz, logic mop,
                              logic halted, int n_wait, logic [31:0] rdata,
                              logic [31:0] exp_wb, logic [3:0] exp_we, logic [31:0] exp_wdata);
    vec_t v;
    v.addr = addr; v.rd_data = rd_data; v.rd_we = rd_we; v.sel = sel; v.des = des;
    v.we_en = we_en; v.byte_sz = byte_sz; v.mop = mop; v.halted = halted; v.n_wait = n_wait;
    v.rdata = rdata; v.exp_wb = exp_wb; v.exp_we = exp_we; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  // Reference model: what the instruction should do, from the architectural rules.
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    int   lane = int'(v.addr % 4);
    if (!v.sel)          r.exp_wb = v.addr;
    else if (v.byte_sz)  r.exp_wb = (v.rdata >> (8 * lane)) & 32'hFF;
    else                 r.exp_wb = v.rdata;
    if (!v.mop || v.we_en == 4'd0) begin
      r.exp_we    = 4'd0;
      r.exp_wdata = 32'd0;
    end else if (v.byte_sz) begin
      r.exp_we    = 4'(1 << lane);
      r.exp_wdata = 32'(v.rd_data[7:0]) * 32'h01010101;
    end else begin
      r.exp_we    = v.we_en;
      r.exp_wdata = v.rd_data;
    end
    return r;
  endfunction

  task automatic idle_inputs();
    EXMEM_is_alu_for_mem_addr = 1'b0;
    EXMEM_mem_write_en        = 4'd0;
    EXMEM_rd_we               = 1'b0;
    EXMEM_internal_halted     = 1'b0;
    dmem_ack                  = 1'b0;
  endtask

  // Entered and left at posedge+1; the bench acts as the memory, acking after n_wait cycles.
  task automatic run(input vec_t v, input string tag);
    int  n_cyc = v.mop ? v.n_wait : 0;
    int  stalls = 0;
    logic exp_stall;
    EXMEM_data_result         = v.addr;
    EXMEM_rd_data             = v.rd_data;
    EXMEM_rd_we               = v.rd_we;
    EXMEM_rd_data_sel         = v.sel;
    EXMEM_des_reg_num         = v.des;
    EXMEM_mem_write_en        = v.we_en;
    EXMEM_ld_byte_or_word     = v.byte_sz;
    EXMEM_is_alu_for_mem_addr = v.mop;
    EXMEM_internal_halted     = v.halted;
    dmem_ack                  = v.mop && (n_cyc == 0);
    dmem_rdata                = dmem_ack ? v.rdata : ~v.rdata;
    for (int c = 0; c <= n_cyc; c++) begin
      #3;
      exp_stall = (c < n_cyc);
      if (mem_stall) stalls++;
      check({tag, " dmem_req"}, 32'(dmem_req), 32'(v.mop));
      check({tag, " MEMID_rd_we"}, 32'(MEMID_rd_we), 32'(v.rd_we && !exp_stall));
      check({tag, " MEMID_rd_num"}, 32'(MEMID_rd_num), 32'(v.des));
      if (v.mop) begin
        check({tag, " dmem_addr"}, 32'(dmem_addr), v.addr >> 2);
        check({tag, " dmem_we"}, 32'(dmem_we), 32'(v.exp_we));
        if (v.exp_we != 4'd0) check({tag, " dmem_wdata"}, dmem_wdata, v.exp_wdata);
      end
      if (!exp_stall) check({tag, " MEMID_forward_data"}, MEMID_forward_data, v.exp_wb);
      @(posedge clk); #1;
      if (exp_stall) begin
        check({tag, " bubble rd_we"}, 32'(MEMWB_rd_we), 32'd0);
        check({tag, " bubble halted"}, 32'(MEMWB_internal_halted), 32'd0);
        check({tag, " bubble data hold"}, MEMWB_wb_data, last_wb);
        dmem_ack   = (c + 1 == n_cyc);
        dmem_rdata = dmem_ack ? v.rdata : ~v.rdata;
      end
    end
    check({tag, " stall cycles"}, 32'(stalls), 32'(n_cyc));
    check({tag, " MEMWB_wb_data"}, MEMWB_wb_data, v.exp_wb);
    check({tag, " MEMWB_rd_we"}, 32'(MEMWB_rd_we), 32'(v.rd_we));
    check({tag, " MEMWB_des"}, 32'(MEMWB_des_reg_num), 32'(v.des));
    check({tag, " MEMWB_halted"}, 32'(MEMWB_internal_halted), 32'(v.halted));
    check({tag, " mem_err"}, 32'(mem_err), 32'd0);
    last_wb  = v.exp_wb;
    last_des = v.des;
    idle_inputs();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " dmem_req"}, 32'(dmem_req), 32'd0);
    check({tag, " MEMWB_wb_data"}, MEMWB_wb_data, 32'd0);
    check({tag, " MEMWB_rd_we"}, 32'(MEMWB_rd_we), 32'd0);
    check({tag, " MEMWB_des"}, 32'(MEMWB_des_reg_num), 32'd0);
    check({tag, " MEMWB_halted"}, 32'(MEMWB_internal_halted), 32'd0);
    check({tag, " mem_err"}, 32'(mem_err), 32'd0);
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    // Directed vectors: expected values written out by hand.
    tbl.push_back(mk(32'h12345678, 32'h0, 1, 0, 4'd3, 4'h0, 0, 0, 0, 0, 32'h0,
                     32'h12345678, 4'h0, 32'h0));
    tbl.push_back(mk(32'h00000100, 32'h0, 1, 1, 4'd5, 4'h0, 0, 1, 0, 0, 32'hDEADBEEF,
                     32'hDEADBEEF, 4'h0, 32'h0));
    tbl.push_back(mk(32'h00000103, 32'h0, 1, 1, 4'd7, 4'h0, 1, 1, 0, 3, 32'hAABBCCDD,
                     32'h000000AA, 4'h0, 32'h0));
    tbl.push_back(mk(32'h00000102, 32'h00000055, 0, 0, 4'd2, 4'h1, 1, 1, 0, 0, 32'h0,
                     32'h00000102, 4'b0100, 32'h55555555));
    tbl.push_back(mk(32'h00000204, 32'hCAFEF00D, 0, 0, 4'd4, 4'hF, 0, 1, 0, 1, 32'h0,
                     32'h00000204, 4'hF, 32'hCAFEF00D));
    tbl.push_back(mk(32'h00000200, 32'h0, 1, 1, 4'd8, 4'h0, 1, 1, 0, 2, 32'h11223344,
                     32'h00000044, 4'h0, 32'h0));
    tbl.push_back(mk(32'h0000ABCD, 32'h0, 0, 0, 4'd0, 4'h0, 0, 0, 1, 0, 32'h0,
                     32'h0000ABCD, 4'h0, 32'h0));

    // Reset with a memory op sitting in EX/MEM: request must stay low.
    last_wb  = 32'd0;
    last_des = 4'd0;
    idle_inputs();
    EXMEM_data_result         = 32'h100;
    EXMEM_rd_data             = 32'h0;
    EXMEM_rd_data_sel         = 1'b1;
    EXMEM_des_reg_num         = 4'd1;
    EXMEM_ld_byte_or_word     = 1'b0;
    EXMEM_is_alu_for_mem_addr = 1'b1;
    dmem_rdata                = 32'h0;
    rst = 1'b1;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();

    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

    // Random instructions against the model.
    for (int i = 0; i < 40; i++) begin
      v.mop     = 1'($urandom_range(0, 3) != 0);
      v.we_en   = (v.mop && $urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      v.byte_sz = 1'($urandom_range(0, 1));
      v.sel     = v.mop && (v.we_en == 4'd0);
      v.addr    = $urandom;
      v.rd_data = $urandom;
      v.rdata   = $urandom;
      v.rd_we   = 1'($urandom_range(0, 1));
      v.des     = 4'($urandom_range(0, 15));
      v.halted  = 1'($urandom_range(0, 7) == 0);
      v.n_wait  = $urandom_range(0, 3);
      run(model(v), $sformatf("rnd%0d", i));
    end

    // Reset in the second WAIT cycle, then a fresh load.
    run(mk(32'h0BADF00D, 32'h0, 1, 0, 4'd9, 4'h0, 0, 0, 1, 0, 32'h0,
           32'h0BADF00D, 4'h0, 32'h0), "pre_rst");
    EXMEM_data_result         = 32'h00000143;
    EXMEM_rd_we               = 1'b1;
    EXMEM_rd_data_sel         = 1'b1;
    EXMEM_des_reg_num         = 4'd6;
    EXMEM_ld_byte_or_word     = 1'b1;
    EXMEM_is_alu_for_mem_addr = 1'b1;
    dmem_ack                  = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
    end
    #2;
    check("midwait req before rst", 32'(dmem_req), 32'd1);
    check("midwait stall before rst", 32'(mem_stall), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midwait_rst");
    check("midwait_rst stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    rst      = 1'b0;
    last_wb  = 32'd0;
    last_des = 4'd0;
    run(mk(32'h00000300, 32'h0, 1, 1, 4'd10, 4'h0, 0, 1, 0, 0, 32'h600DCAFE,
           32'h600DCAFE, 4'h0, 32'h0), "post_rst");

`ifdef ARM_MEM_TIMEOUT_EN
    // Ack never arrives: stall for TO cycles total, the TO-th WAIT cycle drops the op.
    EXMEM_data_result         = 32'h00000400;
    EXMEM_rd_we               = 1'b1;
    EXMEM_rd_data_sel         = 1'b1;
    EXMEM_des_reg_num         = 4'd11;
    EXMEM_ld_byte_or_word     = 1'b0;
    EXMEM_is_alu_for_mem_addr = 1'b1;
    EXMEM_internal_halted     = 1'b1;
    dmem_ack                  = 1'b0;
    for (int c = 0; c <= int'(TO); c++) begin
      #3;
      check($sformatf("timeout stall c%0d", c), 32'(mem_stall), 32'(c < int'(TO)));
      check($sformatf("timeout MEMID_rd_we c%0d", c), 32'(MEMID_rd_we), 32'd0);
      @(posedge clk); #1;
      if (c == int'(TO)) idle_inputs();
      check($sformatf("timeout bubble c%0d", c), 32'(MEMWB_rd_we), 32'd0);
      check($sformatf("timeout halted c%0d", c), 32'(MEMWB_internal_halted), 32'd0);
      check($sformatf("timeout data hold c%0d", c), MEMWB_wb_data, last_wb);
      check($sformatf("timeout mem_err c%0d", c), 32'(mem_err), 32'(c == int'(TO)));
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("timeout req after drop", 32'(dmem_req), 32'd0);
    end
    check("mem_err sticky", 32'(mem_err), 32'd1);
    rst = 1'b1;
    #1;
    check("mem_err after reset", 32'(mem_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_wb = 32'd0;
`else
    // No timeout: a long wait is still just a wait.
    run(mk(32'h00000400, 32'h0, 1, 1, 4'd11, 4'h0, 0, 1, 0, int'(TO) + 2, 32'h87654321,
           32'h87654321, 4'h0, 32'h0), "long_wait");
`endif

    run(mk(32'h00C0FFEE, 32'h0, 1, 0, 4'd12, 4'h0, 0, 0, 0, 0, 32'h0,
           32'h00C0FFEE, 4'h0, 32'h0), "final_alu");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Hard stop in case the stimulus ever stops advancing.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end

endmodule
